// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, line/mask types and clear-sequencer states for the cache data store
package cache_pkg;
  localparam int S_OFFSET = 5;
  localparam int S_INDEX = 3;
  localparam int NUM_WAYS = 4;
  localparam int S_MASK = 2 ** S_OFFSET;
  localparam int S_LINE = 8 * S_MASK;
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int S_WAY = $clog2(NUM_WAYS);
  typedef logic [S_LINE-1:0] line_t;
  typedef logic [S_MASK-1:0] mask_t;
  typedef enum logic {CLEAR, IDLE} clr_state_e;
endpackage

// File: rtl/data_array_nway_if.sv
// data_array_nway_if: read/write/flush request bus and all-ways read return of the data store
interface data_array_nway_if import cache_pkg::*; #(
  parameter int s_offset = S_OFFSET,
  parameter int s_index = S_INDEX,
  parameter int num_ways = NUM_WAYS,
  localparam int s_mask = 2 ** s_offset,
  localparam int s_line = 8 * s_mask,
  localparam int s_way = $clog2(num_ways)
);
  logic flush;
  logic read;
  logic [s_index-1:0] rindex;
  logic [s_mask-1:0] write_en;
  logic [s_index-1:0] windex;
  logic [s_way-1:0] wway;
  logic [s_line-1:0] datain;
  logic [num_ways*s_line-1:0] dataout;
  logic rvalid;
  logic busy;
  modport master (output flush, read, rindex, write_en, windex, wway, datain, input dataout, rvalid, busy);
  modport slave (input flush, read, rindex, write_en, windex, wway, datain, output dataout, rvalid, busy);
endinterface

// File: rtl/data_bank.sv
// data_bank: one way of the array; byte-masked write, set clear, combinational read
module data_bank #(
  parameter int s_offset = 5,
  parameter int s_index = 3,
  localparam int s_mask = 2 ** s_offset,
  localparam int s_line = 8 * s_mask,
  localparam int num_sets = 2 ** s_index
) (
  input  logic clk,
  input  logic clr,
  input  logic [s_index-1:0] clr_idx,
  input  logic [s_mask-1:0] we,
  input  logic [s_index-1:0] windex,
  input  logic [s_line-1:0] datain,
  input  logic [s_index-1:0] rindex,
  output logic [s_line-1:0] rdata
);
  logic [s_line-1:0] mem [num_sets];
  // clear wins; writes never coincide with a clear because the top gates them with busy
  always_ff @(posedge clk) begin
    if (clr) mem[clr_idx] <= '0;
    else for (int i = 0; i < s_mask; i++) if (we[i]) mem[windex][8*i +: 8] <= datain[8*i +: 8];
  end
  assign rdata = mem[rindex];
endmodule

// File: rtl/data_array_nway.sv
// data_array_nway: n-way byte-maskable data store with clear sequencer, write bypass and optional output stage
module data_array_nway import cache_pkg::*; #(
  parameter int s_offset = S_OFFSET,
  parameter int s_index = S_INDEX,
  parameter int num_ways = NUM_WAYS,
  parameter int out_reg = 0,
  localparam int s_mask = 2 ** s_offset,
  localparam int s_line = 8 * s_mask,
  localparam int num_sets = 2 ** s_index,
  localparam int s_way = $clog2(num_ways)
) (
  input logic clk,
  input logic rst,
  data_array_nway_if.slave bus
);
  clr_state_e state;
  logic [s_index:0] clr_idx;
  logic busy_q, acc, v1, v2;
  logic [s_mask-1:0] wr;
  logic [s_index-1:0] r1;
  logic [s_line-1:0] rd [num_ways];
  logic [num_ways*s_line-1:0] fwd, m2, d1, d2;
  function automatic logic [s_line-1:0] mrg(input logic [s_line-1:0] o, input logic [s_line-1:0] n, input logic [s_mask-1:0] m);
    mrg = o;
    for (int i = 0; i < s_mask; i++) if (m[i]) mrg[8*i +: 8] = n[8*i +: 8];
  endfunction
  assign acc = bus.read & ~busy_q;
  assign wr = bus.write_en & {s_mask{~busy_q}};
  // clear sequencer: walks every set once after reset or an accepted flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_idx <= '0;
      busy_q <= 1'b1;
    end else if (state == CLEAR) begin
      state <= clr_idx == (s_index+1)'(num_sets - 1) ? IDLE : CLEAR;
      busy_q <= clr_idx != (s_index+1)'(num_sets - 1);
      clr_idx <= clr_idx == (s_index+1)'(num_sets - 1) ? '0 : clr_idx + 1'b1;
    end else begin
      state <= bus.flush ? CLEAR : IDLE;
      busy_q <= bus.flush;
      clr_idx <= '0;
    end
  end
  for (genvar w = 0; w < num_ways; w++) begin : g_way
    data_bank #(.s_offset(s_offset), .s_index(s_index)) u_bank (
      .clk(clk),
      .clr(state == CLEAR),
      .clr_idx(clr_idx[s_index-1:0]),
      .we(bus.wway == s_way'(w) ? wr : '0),
      .windex(bus.windex),
      .datain(bus.datain),
      .rindex(bus.rindex),
      .rdata(rd[w])
    );
  end
  // same-cycle write bypass into the read, and the late-write merge into the second stage
  always_comb begin
    fwd = '0;
    m2 = '0;
    for (int i = 0; i < num_ways; i++) begin
      fwd[i*s_line +: s_line] = (bus.rindex == bus.windex && bus.wway == s_way'(i)) ? mrg(rd[i], bus.datain, wr) : rd[i];
      m2[i*s_line +: s_line] = (r1 == bus.windex && bus.wway == s_way'(i)) ? mrg(d1[i*s_line +: s_line], bus.datain, wr) : d1[i*s_line +: s_line];
    end
  end
  // read pipeline: stage 1 captures the accepted read, stage 2 adds the following cycle's write
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
      r1 <= '0;
    end else begin
      v1 <= acc;
      v2 <= v1;
      d1 <= acc ? fwd : d1;
      r1 <= acc ? bus.rindex : r1;
      d2 <= v1 ? m2 : d2;
    end
  end
  assign bus.dataout = out_reg != 0 ? d2 : d1;
  assign bus.rvalid = out_reg != 0 ? v2 : v1;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_data_array_nway.sv
// tb_data_array_nway: scoreboard bench driving both output-stage variants with the same directed vectors
module tb_data_array_nway;
  import cache_pkg::*;
  localparam int W = NUM_WAYS * S_LINE;
  typedef struct {
    logic [W-1:0] d;
    int c;
  } ent_t;
  logic clk = 1'b0;
  logic rst, flush, read;
  logic [S_INDEX-1:0] rindex, windex;
  mask_t write_en;
  logic [S_WAY-1:0] wway;
  line_t datain;
  line_t mem [NUM_SETS][NUM_WAYS];
  ent_t q0[$], q1[$];
  int cyc = 0, cmp = 0, bad = 0, m_clr = 0, pidx = 0;
  logic m_busy = 1'b0, mon_en = 1'b0, pend = 1'b0;
  localparam line_t A = {8{32'hA5A5_1234}};
  localparam line_t B = {8{32'h0BAD_F00D}};
  localparam line_t C = {8{32'hC0C0_5566}};
  localparam line_t D = {8{32'hDEAD_BEEF}};
  localparam line_t E = {8{32'h1357_9BDF}};
  always #5 clk = ~clk;
  data_array_nway_if if0();
  data_array_nway_if if1();
  assign if0.flush = flush;
  assign if0.read = read;
  assign if0.rindex = rindex;
  assign if0.write_en = write_en;
  assign if0.windex = windex;
  assign if0.wway = wway;
  assign if0.datain = datain;
  assign if1.flush = flush;
  assign if1.read = read;
  assign if1.rindex = rindex;
  assign if1.write_en = write_en;
  assign if1.windex = windex;
  assign if1.wway = wway;
  assign if1.datain = datain;
  data_array_nway #(.out_reg(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  data_array_nway #(.out_reg(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  function automatic logic [W-1:0] snap(input int s);
    snap = '0;
    for (int w = 0; w < NUM_WAYS; w++) snap[w*S_LINE +: S_LINE] = mem[s][w];
  endfunction
  task automatic step(input logic r, input int ri, input mask_t we, input int wi, input int ww, input line_t d, input logic fl, input logic rs);
    ent_t e;
    logic acc;
    #1;
    rst = rs;
    read = r;
    rindex = S_INDEX'(ri);
    write_en = we;
    windex = S_INDEX'(wi);
    wway = S_WAY'(ww);
    datain = d;
    flush = fl;
    @(posedge clk);
    cyc++;
    if (rs) begin
      m_busy = 1'b1;
      m_clr = 0;
      pend = 1'b0;
      mon_en = 1'b1;
    end else begin
      acc = r && !m_busy;
      if (!m_busy) for (int i = 0; i < S_MASK; i++) if (we[i]) mem[wi][ww][8*i +: 8] = d[8*i +: 8];
      if (pend) begin
        e.d = snap(pidx);
        e.c = cyc;
        q1.push_back(e);
      end
      pend = acc;
      pidx = ri;
      if (m_busy) begin
        for (int w = 0; w < NUM_WAYS; w++) mem[m_clr][w] = '0;
        if (m_clr == NUM_SETS - 1) m_busy = 1'b0;
        else m_clr++;
      end else if (fl) begin
        m_busy = 1'b1;
        m_clr = 0;
      end
      if (acc) begin
        e.d = snap(ri);
        e.c = cyc;
        q0.push_back(e);
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, 0, 0);
  endtask
  task automatic rd(input int s);
    step(1, s, '0, 0, 0, '0, 0, 0);
  endtask
  task automatic wr(input int s, input int w, input mask_t m, input line_t d);
    step(0, 0, m, s, w, d, 0, 0);
  endtask
  task automatic mon(input int g, input logic rv, input logic [W-1:0] dout, input logic bsy);
    ent_t e;
    int n;
    logic ok;
    cmp++;
    if (bsy !== m_busy) begin
      bad++;
      $display("FAIL busy dut%0d cyc %0d: got %b want %b", g, cyc, bsy, m_busy);
    end
    n = g != 0 ? q1.size() : q0.size();
    while (n > 0) begin
      e = g != 0 ? q1[0] : q0[0];
      if (e.c >= cyc) break;
      cmp++;
      bad++;
      $display("FAIL missing_rvalid dut%0d cyc %0d: got none want rvalid at %0d", g, cyc, e.c);
      if (g != 0) q1.delete(0);
      else q0.delete(0);
      n--;
    end
    if (rv !== 1'b0) begin
      cmp++;
      if (n == 0) begin
        bad++;
        $display("FAIL spurious_rvalid dut%0d cyc %0d: got %b want 0", g, cyc, rv);
      end else begin
        e = g != 0 ? q1[0] : q0[0];
        if (g != 0) q1.delete(0);
        else q0.delete(0);
        ok = 1'b1;
        if (e.c != cyc) begin
          ok = 1'b0;
          $display("FAIL rvalid_time dut%0d: got cyc %0d want cyc %0d", g, cyc, e.c);
        end
        for (int w = 0; w < NUM_WAYS; w++)
          if (ok && dout[w*S_LINE +: S_LINE] !== e.d[w*S_LINE +: S_LINE]) begin
            ok = 1'b0;
            $display("FAIL data dut%0d cyc %0d way %0d: got %h want %h", g, cyc, w, dout[w*S_LINE +: S_LINE], e.d[w*S_LINE +: S_LINE]);
          end
        if (!ok) bad++;
      end
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    mon(0, if0.rvalid, if0.dataout, if0.busy);
    mon(1, if1.rvalid, if1.dataout, if1.busy);
  end
  initial begin
    step(0, 0, '0, 0, 0, '0, 0, 1);
    @(negedge clk);
    cmp += 4;
    if (if0.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid dut0: got %b want 0", if0.rvalid); end
    if (if1.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid dut1: got %b want 0", if1.rvalid); end
    if (if0.dataout !== '0) begin bad++; $display("FAIL reset_dataout dut0: got nonzero want 0"); end
    if (if1.dataout !== '0) begin bad++; $display("FAIL reset_dataout dut1: got nonzero want 0"); end
    idle(8);
    for (int s = 0; s < NUM_SETS; s++) rd(s);
    wr(2, 1, '1, A);
    rd(2);
    idle(1);
    wr(5, 3, '1, C);
    wr(4, 3, '1, C);
    step(1, 5, 32'h0000_000F, 5, 3, B, 0, 0);
    step(1, 4, 32'h0000_00F0, 5, 3, E, 0, 0);
    rd(5);
    rd(4);
    idle(1);
    rd(1);
    wr(1, 0, '1, D);
    rd(1);
    idle(2);
    wr(3, 2, '1, E);
    step(1, 3, '0, 0, 0, '0, 1, 0);
    for (int i = 0; i < NUM_SETS; i++) step(1, 3, '1, 3, 2, A, 1, 0);
    for (int s = 0; s < NUM_SETS; s++) rd(s);
    idle(3);
    wr(6, 0, '1, A);
    step(0, 0, '0, 0, 0, '0, 0, 1);
    idle(5);
    step(0, 0, '0, 0, 0, '0, 0, 1);
    for (int i = 0; i < NUM_SETS; i++) step(1, 6, '1, 7, 1, B, 0, 0);
    for (int s = 0; s < NUM_SETS; s++) rd(s);
    idle(4);
    cmp += 2;
    if (q0.size() != 0) begin bad++; $display("FAIL drain dut0: got %0d pending want 0", q0.size()); end
    if (q1.size() != 0) begin bad++; $display("FAIL drain dut1: got %0d pending want 0", q1.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
